aes_round_sched: RTL and testbench
==================================

Name: aes_round_sched

Overview:
- Iterative AES-128 encryption sequencer built around one shared combinational round datapath.
- The datapath computes result = MixColumns(ShiftRows(SubBytes(state ^ key))). When rnd_final=1 it bypasses MixColumns.
- This block loads the plaintext, issues NR datapath passes using round keys 0..NR-1, then applies key NR itself. It returns the ciphertext over a valid/ready handshake.
- Round keys come from the key-expander key store, addressed by key_idx.

Parameters:
- NR, 10, number of datapath passes; AES-128 value.
- IDXW, 4, width of key_idx and rnd_cnt; must satisfy 2^IDXW > NR.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  plaintext offered
- in_ready  out  1  block can accept plaintext
- in_data  in  128  plaintext
- key_valid  in  1  key store holds a complete, valid schedule
- key_idx  out  IDXW  round-key index requested from key store
- key_in  in  128  round key for key_idx, combinational from key store, same cycle
- rnd_state_out  out  128  state to datapath
- rnd_key_out  out  128  key to datapath (= key_in)
- rnd_final  out  1  datapath MixColumns bypass
- rnd_result_in  in  128  datapath result, combinational
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext, registered
- busy  out  1  high in RUN or FIN
- rnd_cnt  out  IDXW  current pass index

Behaviour:
- Reset (async, immediate): FSM=IDLE; state reg, out_data, rnd_cnt=0; out_valid=0; busy=0. Reset mid-operation abandons the block; no partial output.
- FSM states are IDLE, RUN, FIN, DONE.
- IDLE:
  - in_ready=1 in IDLE only.
  - On in_valid&in_ready: state<=in_data, rnd_cnt<=0, go RUN.
- RUN:
  - key_idx=rnd_cnt; rnd_state_out=state; rnd_key_out=key_in; rnd_final=(rnd_cnt==NR-1).
  - If key_valid: state<=rnd_result_in and rnd_cnt<=rnd_cnt+1. If rnd_cnt==NR-1, go FIN instead of incrementing.
  - If !key_valid: hold everything (stall).
- FIN:
  - key_idx=NR.
  - If key_valid: out_data<=state^key_in, go DONE. Else stall.
- DONE:
  - out_valid=1; out_data stable.
  - On out_ready: go IDLE, out_valid<=0.
  - No new input is accepted while DONE, including in the same cycle as out_ready.
- Outputs outside RUN:
  - rnd_final=0; rnd_state_out=state; rnd_key_out=key_in.
  - key_idx=0 in IDLE, NR in FIN and DONE.
- busy = (FSM==RUN or FIN).
- Latency with key_valid held high: out_valid rises on the NR+1th rising edge after the accepting edge (11 for NR=10). Each key_valid-low cycle adds 1.
- Throughput: one block per NR+3 cycles minimum (accept cycle + RUN + FIN + one DONE cycle).
- rnd_cnt never exceeds NR-1 in RUN. No wrap-around.
- key_valid dropping mid-block stalls only. A mid-block key change is the requester's responsibility and is not detected.
- in_data is sampled only on the accepting edge; changes afterwards are ignored.

Test Plan:
- FIPS-197 App. B, key_valid=1: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, out_ready=1 -> out_data=3925841d02dc09fbdc118597196a0b32; out_valid 11 edges after accept; rnd_final high only when rnd_cnt=9.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data=69c4e0d86a7b0430d8cdb78070b4c55a.
- Stall: App. B vector with key_valid low for 3 cycles at rnd_cnt=4 and 1 cycle in FIN -> same ciphertext; out_valid at edge 15; rnd_cnt frozen during stall.
- Backpressure: out_ready low 5 cycles in DONE -> out_valid and out_data stable; in_ready=0; in_valid pulses ignored. Then out_ready=1 -> IDLE next edge; the following block is accepted and correct.
- Reset mid-block: assert rst at rnd_cnt=6 -> immediately out_valid=0, busy=0, in_ready=1, rnd_cnt=0. The next App. C.1 block produces the correct ciphertext.
- Back-to-back: 4 random blocks with in_valid held high and out_ready=1 -> each accepted NR+3 cycles apart; outputs match a software AES model in order.

Source files
------------

// File: rtl/aes_round_sched.sv
// Iterative AES-128 encryption sequencer: drives one shared round datapath NR times,
// then applies the last round key and returns the ciphertext over valid/ready.
module aes_round_sched #(
  parameter int unsigned NR   = 10,
  parameter int unsigned IDXW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  input  logic            key_valid,
  output logic [IDXW-1:0] key_idx,
  input  logic [127:0]    key_in,
  output logic [127:0]    rnd_state_out,
  output logic [127:0]    rnd_key_out,
  output logic            rnd_final,
  input  logic [127:0]    rnd_result_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic            busy,
  output logic [IDXW-1:0] rnd_cnt
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NR - 1);
  localparam logic [IDXW-1:0] FIN_IDX  = IDXW'(NR);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN,
    S_DONE
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [127:0]    state_q, state_d;
  logic [127:0]    out_data_q, out_data_d;
  logic [IDXW-1:0] rnd_cnt_q, rnd_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      state_q    <= '0;
      out_data_q <= '0;
      rnd_cnt_q  <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
      rnd_cnt_q  <= rnd_cnt_d;
    end
  end

  // Next-state and output decode; every key_valid-low cycle simply holds all state.
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    out_data_d = out_data_q;
    rnd_cnt_d  = rnd_cnt_q;
    in_ready   = 1'b0;
    key_idx    = '0;
    rnd_final  = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;

    unique case (fsm_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d   = in_data;
          rnd_cnt_d = '0;
          fsm_d     = S_RUN;
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        key_idx   = rnd_cnt_q;
        rnd_final = (rnd_cnt_q == LAST_IDX);
        if (key_valid) begin
          state_d = rnd_result_in;
          if (rnd_cnt_q == LAST_IDX) begin
            fsm_d = S_FIN;
          end else begin
            rnd_cnt_d = rnd_cnt_q + IDXW'(1);
          end
        end
      end
      S_FIN: begin
        busy    = 1'b1;
        key_idx = FIN_IDX;
        if (key_valid) begin
          out_data_d = state_q ^ key_in;
          fsm_d      = S_DONE;
        end
      end
      S_DONE: begin
        key_idx   = FIN_IDX;
        out_valid = 1'b1;
        if (out_ready) begin
          fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  assign rnd_state_out = state_q;
  assign rnd_key_out   = key_in;
  assign out_data      = out_data_q;
  assign rnd_cnt       = rnd_cnt_q;

endmodule

// File: tb/tb_aes_round_sched.sv
// Directed bench for aes_round_sched with a behavioural key store and round datapath
// built around it; known-answer FIPS-197 vectors plus stall, backpressure and reset cases.
module tb_aes_round_sched;

  localparam int unsigned NR   = 10;
  localparam int unsigned IDXW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [127:0]    in_data;
  logic            key_valid;
  logic [IDXW-1:0] key_idx;
  logic [127:0]    key_in;
  logic [127:0]    rnd_state_out;
  logic [127:0]    rnd_key_out;
  logic            rnd_final;
  logic [127:0]    rnd_result_in;
  logic            out_valid;
  logic            out_ready;
  logic [127:0]    out_data;
  logic            busy;
  logic [IDXW-1:0] rnd_cnt;

  int assertions = 0;
  int failures   = 0;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_sched #(.NR(NR), .IDXW(IDXW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .key_valid(key_valid), .key_idx(key_idx), .key_in(key_in),
    .rnd_state_out(rnd_state_out), .rnd_key_out(rnd_key_out), .rnd_final(rnd_final),
    .rnd_result_in(rnd_result_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .rnd_cnt(rnd_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural AES pieces ----------------
  logic [7:0]         sbox [256];
  logic [15:0][127:0] rk;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, b} << k;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  function automatic logic [15:0][127:0] expand(input logic [127:0] key);
    logic [31:0]        w [44];
    logic [31:0]        t;
    logic [7:0]         rcon;
    logic [15:0][127:0] k;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    k = '0;
    for (int r = 0; r <= 10; r++) k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return k;
  endfunction

  // MixColumns(ShiftRows(SubBytes(s))), MixColumns skipped when fin is set.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int j = 0; j < 16; j++) sb[j] = sbox[s[127-8*j -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = sr[4*c]; a1 = sr[4*c+1]; a2 = sr[4*c+2]; a3 = sr[4*c+3];
        sr[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        sr[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        sr[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        sr[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int j = 0; j < 16; j++) o[127-8*j -: 8] = sr[j];
    return o;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [15:0][127:0] k);
    logic [127:0] s;
    s = pt;
    for (int r = 0; r < 10; r++) s = aes_round(s ^ k[r], r == 9);
    return s ^ k[10];
  endfunction

  assign key_in = rk[key_idx];
  always_comb rnd_result_in = aes_round(rnd_state_out ^ rnd_key_out, rnd_final);

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_block(input logic [127:0] pt, input string name);
    int w;
    w = 0;
    while (!in_ready && w < 30) begin tick(); w++; end
    assertions++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready timeout: got %b required 1", name, in_ready);
    end
    in_valid = 1'b1;
    in_data  = pt;
    tick();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // One block with key_valid high: per-pass index checks, latency and ciphertext.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] ct, input string name);
    int done;
    done = -1;
    out_ready = 1'b1;
    accept_block(pt, name);
    for (int e = 0; e < 40; e++) begin
      if (e <= 9) begin
        assertions++;
        if (rnd_cnt !== IDXW'(e) || key_idx !== IDXW'(e) || rnd_final !== (e == 9) || busy !== 1'b1) begin
          failures++;
          $display("FAIL %s pass %0d: rnd_cnt=%0d key_idx=%0d final=%b busy=%b required %0d/%0d/%b/1",
                   name, e, rnd_cnt, key_idx, rnd_final, busy, e, e, e == 9);
        end
      end else if (e == 10) begin
        assertions++;
        if (key_idx !== IDXW'(NR) || rnd_final !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s fin: key_idx=%0d final=%b busy=%b out_valid=%b required 10/0/1/0",
                   name, key_idx, rnd_final, busy, out_valid);
        end
      end
      tick();
      if (out_valid) begin done = e + 1; break; end
    end
    assertions++;
    if (done != NR + 1) begin
      failures++;
      $display("FAIL %s latency: got %0d edges required %0d", name, done, NR + 1);
    end
    assertions++;
    if (out_data !== ct || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s result: data=%h busy=%b in_ready=%b required %h/0/0", name, out_data, busy, in_ready, ct);
    end
    tick();
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s release: out_valid=%b in_ready=%b required 0/1", name, out_valid, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    assertions++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || rnd_cnt !== '0 ||
        out_data !== '0 || key_idx !== '0 || rnd_final !== 1'b0 || rnd_state_out !== '0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b rnd_cnt=%0d out_data=%h key_idx=%0d final=%b required 1/0/0/0/0/0/0",
               in_ready, out_valid, busy, rnd_cnt, out_data, key_idx, rnd_final);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_b();
    rk = expand(KEY_B);
    assertions++;
    if (aes_model(PT_B, rk) !== CT_B) begin
      failures++;
      $display("FAIL model_b: got %h required %h", aes_model(PT_B, rk), CT_B);
    end
    run_block(PT_B, CT_B, "fips_b");
  endtask

  task automatic test_fips_c();
    rk = expand(KEY_C);
    run_block(PT_C, CT_C, "fips_c1");
  endtask

  task automatic test_stall();
    int done;
    done = -1;
    rk = expand(KEY_B);
    out_ready = 1'b1;
    accept_block(PT_B, "stall");
    for (int e = 1; e <= 40; e++) begin
      key_valid = !(e inside {5, 6, 7, 14});
      tick();
      if (e >= 5 && e <= 7) begin
        assertions++;
        if (rnd_cnt !== IDXW'(4) || busy !== 1'b1) begin
          failures++;
          $display("FAIL stall frozen edge %0d: rnd_cnt=%0d busy=%b required 4/1", e, rnd_cnt, busy);
        end
      end
      if (e == 14) begin
        assertions++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || key_idx !== IDXW'(NR)) begin
          failures++;
          $display("FAIL stall fin hold: busy=%b out_valid=%b key_idx=%0d required 1/0/10", busy, out_valid, key_idx);
        end
      end
      if (out_valid) begin done = e; break; end
    end
    key_valid = 1'b1;
    assertions++;
    if (done != 15) begin
      failures++;
      $display("FAIL stall latency: got %0d edges required 15", done);
    end
    assertions++;
    if (out_data !== CT_B) begin
      failures++;
      $display("FAIL stall data: got %h required %h", out_data, CT_B);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int w;
    rk = expand(KEY_B);
    out_ready = 1'b0;
    accept_block(PT_B, "bp");
    w = 0;
    while (!out_valid && w < 40) begin tick(); w++; end
    for (int i = 0; i < 5; i++) begin
      assertions++;
      if (out_valid !== 1'b1 || out_data !== CT_B || in_ready !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL bp hold %0d: out_valid=%b data=%h in_ready=%b busy=%b required 1/%h/0/0",
                 i, out_valid, out_data, in_ready, busy, CT_B);
      end
      in_valid = (i % 2 == 0);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    assertions++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bp release: out_valid=%b in_ready=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
    in_valid = 1'b0;
    run_block(PT_B, CT_B, "bp_next");
  endtask

  task automatic test_reset_mid();
    rk = expand(KEY_C);
    out_ready = 1'b1;
    accept_block(PT_C, "rst_mid");
    for (int i = 0; i < 6; i++) tick();
    assertions++;
    if (rnd_cnt !== IDXW'(6)) begin
      failures++;
      $display("FAIL rst_mid precondition: rnd_cnt=%0d required 6", rnd_cnt);
    end
    rst = 1'b1;
    #1;
    assertions++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || rnd_cnt !== '0) begin
      failures++;
      $display("FAIL rst_mid async: out_valid=%b busy=%b in_ready=%b rnd_cnt=%0d required 0/0/1/0",
               out_valid, busy, in_ready, rnd_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
    run_block(PT_C, CT_C, "rst_mid_next");
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [4];
    logic [127:0] exp [4];
    bit acc;
    int acc_cnt, out_cnt, last_acc, cyc;
    rk = expand({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) begin
      pts[i] = {$urandom, $urandom, $urandom, $urandom};
      exp[i] = aes_model(pts[i], rk);
    end
    acc_cnt = 0; out_cnt = 0; last_acc = 0; cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = pts[0];
    while (out_cnt < 4 && cyc < 200) begin
      acc = in_ready && in_valid;
      tick();
      cyc++;
      if (acc) begin
        if (acc_cnt > 0) begin
          assertions++;
          if (cyc - last_acc != NR + 3) begin
            failures++;
            $display("FAIL b2b spacing %0d: got %0d cycles required %0d", acc_cnt, cyc - last_acc, NR + 3);
          end
        end
        last_acc = cyc;
        acc_cnt++;
        if (acc_cnt < 4) in_data = pts[acc_cnt];
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        assertions++;
        if (out_data !== exp[out_cnt]) begin
          failures++;
          $display("FAIL b2b data %0d: got %h required %h", out_cnt, out_data, exp[out_cnt]);
        end
        out_cnt++;
      end
    end
    in_valid = 1'b0;
    assertions++;
    if (out_cnt != 4) begin
      failures++;
      $display("FAIL b2b count: got %0d outputs required 4", out_cnt);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    key_valid = 1'b1;
    out_ready = 1'b1;
    rk        = '0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    end

    test_reset();
    test_fips_b();
    test_fips_c();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
